wb_prog_loader: RTL and testbench
=================================

// Module: wb_prog_loader
// PURPOSE
//  Wishbone initiator (master) that streams a program image, byte by byte, into the
//  jacaranda-8 instruction memory through the design's Wishbone responder.
//  Sits between a byte source (UART receiver / host FIFO) and the Wishbone bus.
//  Used while the core is held in reset to load the 256-byte instruction memory.
// PARAMETERS
//  ADDR_STRIDE   4    address increment per byte (word-addressed slave)
//  LEN_W         9    width of length/count (max 256 bytes)
//  TIMEOUT       255  cycles to wait for wbm_ack_i before aborting the transfer
// PORTS
//  wb_clk_i      in   1      clock
//  wb_rst_i      in   1      synchronous active-high reset
//  start         in   1      pulse: begin load (ignored while busy)
//  base_addr     in   32     byte-0 address; sampled on accepted start
//  length        in   LEN_W  number of bytes; sampled on accepted start
//  s_data        in   8      program byte
//  s_valid       in   1      s_data valid
//  s_ready       out  1      loader accepts s_data this cycle
//  wbm_cyc_o     out  1      Wishbone cycle
//  wbm_stb_o     out  1      Wishbone strobe
//  wbm_we_o      out  1      write enable
//  wbm_sel_o     out  4      byte select, always 4'b0001
//  wbm_adr_o     out  32     address
//  wbm_dat_o     out  32     write data, {24'b0, byte}
//  wbm_dat_i     in   32     read data (used only with verify)
//  wbm_ack_i     in   1      acknowledge
//  busy          out  1      transfer in progress
//  done          out  1      one-cycle pulse at end of transfer (success or error)
//  error         out  1      sticky: timeout or verify mismatch; cleared on next start
//  count         out  LEN_W  bytes written and acknowledged so far
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; cyc/stb drop at the reset edge even mid-cycle.
//  FSM: IDLE -> WAIT_DATA -> WRITE -> (VERIFY) -> WAIT_DATA ... -> DONE -> IDLE.
//  IDLE: start=1 latches base_addr/length, clears count/error, busy=1 next cycle.
//    length==0: go straight to DONE; no bus traffic.
//  WAIT_DATA: s_ready=1; byte accepted on s_valid&s_ready; next cycle enters WRITE
//    with cyc=stb=we=1, adr=base_addr+count*ADDR_STRIDE (32-bit wrap), dat={24'b0,byte}.
//  WRITE: cyc/stb/adr/dat held stable until ack sampled high; cyc/stb low the
//    following cycle; count increments on that ack edge. No back-to-back: at least one
//    idle bus cycle between transactions.
//  After ack: count==length -> DONE, else WAIT_DATA.
//  Timeout: counter cleared on each cycle start; if TIMEOUT cycles elapse without ack,
//    drop cyc/stb, error=1, go DONE; count not incremented.
//  ack while cyc=0 ignored. start while busy ignored. s_ready=0 outside WAIT_DATA.
//  DONE: done=1 and busy=0 for exactly one cycle, then IDLE; start in DONE ignored.
// CONFIGURATION
//  WB_LOADER_VERIFY_EN defined: after each write ack, one idle cycle, then a read cycle
//    (we=0, same adr/sel) in VERIFY; on ack compare wbm_dat_i[7:0] to the byte;
//    mismatch -> error=1, DONE. count increments only after a matching read-back.
//    Timeout applies to the read cycle too.
//  Not defined: no VERIFY state; wbm_we_o=1 whenever cyc=1; wbm_dat_i unused.
// TESTING
//  1 base=0x3000_0000,len=3, bytes 0x11,0x22,0x33, ack 1 cycle after stb -> writes to
//    0x3000_0000/04/08 data 0x11/22/33, sel=0001, count=3, done pulse, error=0.
//  2 len=0, start -> done pulse after 1 cycle, cyc never asserted, count=0.
//  3 ack withheld on byte 2 -> cyc/stb drop after 255 cycles, error=1, count=1, done.
//  4 s_valid gaps of 5 cycles, ack delay 3 cycles -> adr/dat stable through delay,
//    one idle cycle between cycles, final count=len.
//  5 wb_rst_i during WRITE with stb=1 -> next edge cyc=stb=busy=0; new start works.
//  6 VERIFY_EN, slave returns 0xFF for 0x22 -> read cycle at same adr, error=1, count=1.

Source files
------------

// File: rtl/wb_prog_loader.sv
// wb_prog_loader: Wishbone initiator streaming program bytes into instruction memory.
// Define WB_LOADER_VERIFY_EN to read back and compare every byte after its write.
module wb_prog_loader #(
  parameter int ADDR_STRIDE = 4,
  parameter int LEN_W = 9,
  parameter int TIMEOUT = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [LEN_W-1:0] length,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [LEN_W-1:0] count
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, WAIT_DATA, WRITE, GAP, VERIFY, DONE} state_t;
  state_t           state_q, state_d;
  logic [31:0]      base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d, count_q, count_d;
  logic [7:0]       byte_q, byte_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic             error_q, error_d;
  logic             cyc, last, tmo;
  assign cyc  = (state_q == WRITE) || (state_q == VERIFY);
  assign last = (count_q + LEN_W'(1)) == len_q;
  assign tmo  = tmr_q == TW'(TIMEOUT - 1);
`ifndef WB_LOADER_VERIFY_EN
  logic unused_dat;
  assign unused_dat = ^wbm_dat_i;
`endif
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    count_d = count_q;
    byte_d  = byte_q;
    error_d = error_q;
    tmr_d   = cyc ? tmr_q + TW'(1) : '0;
    case (state_q)
      IDLE: if (start) begin
        base_d  = base_addr;
        len_d   = length;
        count_d = '0;
        error_d = 1'b0;
        state_d = (length == '0) ? DONE : WAIT_DATA;
      end
      WAIT_DATA: if (s_valid) begin
        byte_d  = s_data;
        state_d = WRITE;
      end
      WRITE: if (wbm_ack_i) begin
`ifdef WB_LOADER_VERIFY_EN
        state_d = GAP;
`else
        count_d = count_q + LEN_W'(1);
        state_d = last ? DONE : WAIT_DATA;
`endif
      end else if (tmo) begin
        error_d = 1'b1;
        state_d = DONE;
      end
`ifdef WB_LOADER_VERIFY_EN
      GAP: state_d = VERIFY;
      VERIFY: if (wbm_ack_i) begin
        if (wbm_dat_i[7:0] == byte_q) begin
          count_d = count_q + LEN_W'(1);
          state_d = last ? DONE : WAIT_DATA;
        end else begin
          error_d = 1'b1;
          state_d = DONE;
        end
      end else if (tmo) begin
        error_d = 1'b1;
        state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
      byte_q  <= '0;
      tmr_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      count_q <= count_d;
      byte_q  <= byte_d;
      tmr_q   <= tmr_d;
      error_q <= error_d;
    end
  end
  assign s_ready   = state_q == WAIT_DATA;
  assign wbm_cyc_o = cyc;
  assign wbm_stb_o = cyc;
  assign wbm_we_o  = state_q == WRITE;
  assign wbm_sel_o = {3'b000, cyc};
  assign wbm_adr_o = base_q + 32'(count_q) * 32'(ADDR_STRIDE);
  assign wbm_dat_o = {24'h0, byte_q};
  assign busy      = cyc || (state_q == WAIT_DATA) || (state_q == GAP);
  assign done      = state_q == DONE;
  assign error     = error_q;
  assign count     = count_q;
endmodule

// File: tb/tb_wb_prog_loader.sv
// tb_wb_prog_loader: table, directed and random loads against a transaction-list model.
module tb_wb_prog_loader;
  localparam int LEN_W = 9;
  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i = 1'b1;
  logic             start = 1'b0;
  logic [31:0]      base_addr = '0;
  logic [LEN_W-1:0] length = '0;
  logic [7:0]       s_data = '0;
  logic             s_valid = 1'b0;
  logic             s_ready;
  logic             wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]       wbm_sel_o;
  logic [31:0]      wbm_adr_o, wbm_dat_o;
  logic [31:0]      wbm_dat_i = '0;
  logic             wbm_ack_i = 1'b0;
  logic             busy, done, error;
  logic [LEN_W-1:0] count;

  wb_prog_loader dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .start(start), .base_addr(base_addr),
    .length(length), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .busy(busy), .done(done),
    .error(error), .count(count)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
  } tx_t;

  typedef struct {
    logic [31:0] base;
    int          len, dly, gap, wh, cor;
    bit          xs;
    int          ec;
    bit          ee;
  } vec_t;

  tx_t        txq[$], expq[$];
  logic [7:0] bytes[0:255];
  logic [7:0] srcq[$];
  int ack_delay = 1, withhold = -1, corrupt = -1, src_gap = 0;
  int wr_idx = 0, rd_idx = 0, stab_err = 0, b2b_err = 0, held_len = 0;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Wishbone responder: records each transaction, acks after ack_delay wait cycles
  initial begin : slave
    int wcnt;
    bit hold;
    tx_t cur;
    logic [7:0] last_wr;
    logic [31:0] r;
    wcnt = 0; hold = 0; cur = '0; last_wr = '0;
    forever begin
      @(negedge wb_clk_i);
      if (wbm_ack_i) begin
        wbm_ack_i = 1'b0;
        wcnt = 0;
        if (wbm_cyc_o) b2b_err++;
      end else if (wbm_cyc_o && wbm_stb_o) begin
        if (wcnt == 0) begin
          cur = {wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o};
          txq.push_back(cur);
          hold = wbm_we_o && (wr_idx == withhold);
          if (wbm_we_o) begin
            wr_idx++;
            last_wr = wbm_dat_o[7:0];
          end
        end else if (cur != {wbm_adr_o, wbm_dat_o, wbm_we_o, wbm_sel_o}) stab_err++;
        wcnt++;
        if (!hold && wcnt > ack_delay) begin
          wbm_ack_i = 1'b1;
          if (!wbm_we_o) begin
            r = $urandom();
            wbm_dat_i = {r[31:8], (rd_idx == corrupt) ? ((last_wr == 8'hFF) ? 8'h00 : 8'hFF) : last_wr};
            rd_idx++;
          end
        end
      end else begin
        if (hold && wcnt > 0) held_len = wcnt;
        hold = 0;
        wcnt = 0;
      end
    end
  end

  // Byte source: presents srcq bytes, idling src_gap cycles after each accepted byte
  initial begin : source
    int gap;
    bit prev_ready;
    gap = 0; prev_ready = 0;
    forever begin
      @(negedge wb_clk_i);
      if (s_valid && prev_ready && srcq.size() > 0) begin
        void'(srcq.pop_front());
        s_valid = 1'b0;
        gap = src_gap;
      end
      if (!s_valid && srcq.size() > 0) begin
        if (gap == 0) begin
          s_valid = 1'b1;
          s_data = srcq[0];
        end else gap--;
      end
      prev_ready = s_ready;
    end
  end

  task automatic model(input logic [31:0] base, input int len, input int wh,
                       output int ec, output bit ee, output bit et);
    logic [31:0] a;
    expq.delete();
    ec = 0; ee = 0; et = 0;
    for (int i = 0; i < len; i++) begin
      a = base + 32'(i) * 32'd4;
      expq.push_back({a, {24'h0, bytes[i]}, 1'b1, 4'b0001});
      if (i == wh) begin
        ee = 1; et = 1;
        break;
      end
`ifdef WB_LOADER_VERIFY_EN
      expq.push_back({a, {24'h0, bytes[i]}, 1'b0, 4'b0001});
      if (i == corrupt) begin
        ee = 1;
        break;
      end
`endif
      ec = i + 1;
    end
  endtask

  task automatic run(input logic [31:0] base, input int len, input int dly, input int gap,
                     input int wh, input int cor, input bit xs, output int gc, output bit ge);
    int ec, t;
    bit ee, et;
    txq.delete(); srcq.delete(); s_valid = 1'b0;
    for (int i = 0; i < len; i++) srcq.push_back(bytes[i]);
    ack_delay = dly; src_gap = gap; withhold = wh; corrupt = cor;
    wr_idx = 0; rd_idx = 0; stab_err = 0; b2b_err = 0; held_len = 0;
    model(base, len, wh, ec, ee, et);
    @(negedge wb_clk_i);
    base_addr = base; length = LEN_W'(len); start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0; base_addr = $urandom(); length = LEN_W'($urandom_range(1, 9));
    if (len > 0) chk("busy_after_start", busy, 1);
    if (xs) begin
      repeat (3) @(negedge wb_clk_i);
      start = 1'b1; base_addr = 32'hDEAD_0000; length = 1;
      @(negedge wb_clk_i);
      start = 1'b0;
    end
    t = 0;
    while (!done && t < 20000) begin
      @(negedge wb_clk_i);
      t++;
    end
    chk("done_seen", done, 1);
    chk("busy_in_done", busy, 0);
    chk("count", count, ec);
    chk("error", error, ee);
    chk("tx_count", txq.size(), expq.size());
    for (int i = 0; i < txq.size() && i < expq.size(); i++) chk($sformatf("tx%0d", i), txq[i], expq[i]);
    chk("adr_dat_stable", stab_err, 0);
    chk("idle_between_cycles", b2b_err, 0);
    if (et) chk("timeout_cycles", held_len, 255);
    gc = count; ge = error;
    @(negedge wb_clk_i);
    chk("done_one_cycle", done, 0);
    chk("error_sticky", error, ee);
    srcq.delete(); s_valid = 1'b0;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    vec_t tbl[$];
    int gc, t, len, wh, cor;
    bit ge;
    logic [31:0] base;
    for (int i = 0; i < 256; i++) bytes[i] = 8'((i + 1) * 17);
    repeat (3) @(negedge wb_clk_i);
    chk("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    chk("idle_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 0);
    chk("idle_adr_dat", {wbm_adr_o, wbm_dat_o}, 0);
    chk("idle_status", {busy, done, error, s_ready}, 0);
    chk("idle_count", count, 0);

    txq.delete();
    base_addr = 32'h5000; length = 0; start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    chk("len0_done", done, 1);
    chk("len0_busy", busy, 0);
    chk("len0_count", count, 0);
    start = 1'b1; length = 1;
    @(negedge wb_clk_i);
    start = 1'b0;
    chk("len0_done_pulse", done, 0);
    chk("start_in_done_ignored", busy, 0);
    chk("len0_no_bus", txq.size(), 0);

    tbl.push_back('{32'h3000_0000, 3, 1, 0, -1, -1, 0, 3, 0});
    tbl.push_back('{32'h3000_0000, 3, 1, 0, 1, -1, 0, 1, 1});
    tbl.push_back('{32'h0000_1000, 4, 3, 5, -1, -1, 1, 4, 0});
    tbl.push_back('{32'hFFFF_FFF8, 4, 0, 0, -1, -1, 0, 4, 0});
    tbl.push_back('{32'h0000_0000, 256, 0, 0, -1, -1, 0, 256, 0});
    tbl.push_back('{32'h0000_0100, 2, 2, 1, 0, -1, 0, 0, 1});
`ifdef WB_LOADER_VERIFY_EN
    tbl.push_back('{32'h3000_0000, 3, 1, 0, -1, 1, 0, 1, 1});
`endif
    foreach (tbl[k]) begin
      run(tbl[k].base, tbl[k].len, tbl[k].dly, tbl[k].gap, tbl[k].wh, tbl[k].cor, tbl[k].xs, gc, ge);
      chk($sformatf("tbl%0d_count", k), gc, tbl[k].ec);
      chk($sformatf("tbl%0d_error", k), ge, tbl[k].ee);
    end

    srcq.delete();
    for (int i = 0; i < 4; i++) srcq.push_back(bytes[i]);
    ack_delay = 10; withhold = -1; corrupt = -1; src_gap = 0; wr_idx = 0; rd_idx = 0;
    base_addr = 32'h2000; length = 4; start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    t = 0;
    while (!wbm_stb_o && t < 100) begin
      @(negedge wb_clk_i);
      t++;
    end
    chk("rst_reach_write", wbm_stb_o, 1);
    wb_rst_i = 1'b1; srcq.delete(); s_valid = 1'b0;
    @(negedge wb_clk_i);
    chk("rst_mid_cycle", {wbm_cyc_o, wbm_stb_o, busy}, 0);
    wb_rst_i = 1'b0;
    run(32'h3000_0000, 3, 1, 0, -1, -1, 0, gc, ge);
    chk("after_rst_count", gc, 3);

    for (int n = 0; n < 25; n++) begin
      len = $urandom_range(1, 16);
      for (int i = 0; i < len; i++) bytes[i] = 8'($urandom());
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 + 32'($urandom_range(0, 7) * 4) : $urandom();
      wh  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      cor = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      run(base, len, $urandom_range(0, 4), $urandom_range(0, 3), wh, cor, 0, gc, ge);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
